sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 14 +
 rtl/sdram_arb_tmo.sv | 21 ++
 rtl/sdram_arbiter.sv | 85 ++++++++
 tb/tb_sdram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: FSM state encoding and bus widths shared by the SDRAM arbiter files
package sdram_arbiter_pkg;
  localparam int ADR_W = 21;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2,
    ERR  = 3'd3,
    REL  = 3'd4
  } state_t;
endpackage

// File: rtl/sdram_arb_tmo.sv
// sdram_arb_tmo: saturating no-ack cycle counter; expired flags the last allowed grant cycle
module sdram_arb_tmo
  import sdram_arbiter_pkg::*;
#(
  parameter int TMO_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : (run && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // cnt_q counts completed no-ack grant cycles, so TMO_CYCLES-1 marks the final one
  assign expired = run && !clr && cnt_q >= CNT_W'(TMO_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin two-master arbiter for a single SDRAM slave with ack timeout
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int TMO_CYCLES = 1023
) (
  input  logic             clk_p,
  input  logic             sdram_reset,
  input  logic             m0_stb,
  input  logic             m1_stb,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [SEL_W-1:0] m0_sel,
  input  logic [SEL_W-1:0] m1_sel,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m0_dat_o,
  input  logic [DAT_W-1:0] m1_dat_o,
  output logic             m0_ack,
  output logic             m1_ack,
  output logic             m0_err,
  output logic             m1_err,
  output logic [DAT_W-1:0] m_dat_i,
  output logic             sdram_stb,
  output logic             sdram_we,
  output logic [SEL_W-1:0] sdram_sel,
  output logic [ADR_W-1:0] sdram_adr,
  output logic [DAT_W-1:0] sdram_out,
  input  logic             sdram_ack,
  input  logic             sdram_ready,
  input  logic [DAT_W-1:0] sdram_dat,
  output logic             tmo_flag
);
  state_t state_q, state_d;
  logic   last_q, last_d, stb_q, tmo_q, tmo_d, expired, gnt, gnt1;
  assign gnt  = state_q == GNT0 || state_q == GNT1;
  assign gnt1 = state_q == GNT1;
  sdram_arb_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .clk     (clk_p),
    .rst     (sdram_reset),
    .clr     (!gnt || sdram_ack),
    .run     (gnt),
    .expired (expired)
  );
  // last_q also names the owner while in ERR, since it is updated on every grant
  always_ff @(posedge clk_p or posedge sdram_reset) begin
    if (sdram_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      stb_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stb_q   <= state_d == GNT0 || state_d == GNT1;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sdram_ready && (m0_stb || m1_stb))
                 state_d = (m0_stb && (!m1_stb || last_q)) ? GNT0 : GNT1;
      GNT0:    state_d = !m0_stb ? REL : expired ? ERR : GNT0;
      GNT1:    state_d = !m1_stb ? REL : expired ? ERR : GNT1;
      ERR:     state_d = (last_q ? m1_stb : m0_stb) ? ERR : REL;
      default: state_d = IDLE;
    endcase
    last_d = state_d == GNT0 ? 1'b0 : state_d == GNT1 ? 1'b1 : last_q;
    tmo_d  = tmo_q || state_d == ERR;
  end
  always_comb begin
    sdram_we  = gnt && (gnt1 ? m1_we : m0_we);
    sdram_sel = gnt ? (gnt1 ? m1_sel : m0_sel) : '0;
    sdram_adr = gnt ? (gnt1 ? m1_adr : m0_adr) : '0;
    sdram_out = gnt ? (gnt1 ? m1_dat_o : m0_dat_o) : '0;
    m0_ack    = sdram_ack && state_q == GNT0;
    m1_ack    = sdram_ack && gnt1;
    m0_err    = state_q == ERR && !last_q && m0_stb;
    m1_err    = state_q == ERR && last_q && m1_stb;
  end
  assign sdram_stb = stb_q;
  assign tmo_flag  = tmo_q;
  assign m_dat_i   = sdram_dat;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed stimulus with a scoreboard checked on every ack / err onset
module tb_sdram_arbiter;
  logic        clk_p = 1'b0, sdram_reset = 1'b1;
  logic        m0_stb, m1_stb, m0_we, m1_we, sdram_ack, sdram_ready;
  logic [1:0]  m0_sel, m1_sel;
  logic [20:0] m0_adr, m1_adr;
  logic [15:0] m0_dat_o, m1_dat_o, sdram_dat;
  logic        m0_ack, m1_ack, m0_err, m1_err, sdram_stb, sdram_we, tmo_flag;
  logic [15:0] m_dat_i, sdram_out;
  logic [1:0]  sdram_sel;
  logic [20:0] sdram_adr;

  always #5 clk_p = ~clk_p;

  sdram_arbiter #(.TMO_CYCLES(8)) dut (
    .clk_p(clk_p), .sdram_reset(sdram_reset),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_we(m0_we), .m1_we(m1_we),
    .m0_sel(m0_sel), .m1_sel(m1_sel), .m0_adr(m0_adr), .m1_adr(m1_adr),
    .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
    .m_dat_i(m_dat_i), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out),
    .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .sdram_dat(sdram_dat),
    .tmo_flag(tmo_flag)
  );

  // kind: 0 = m0 ack, 1 = m1 ack, 2 = m0 err onset, 3 = m1 err onset
  typedef struct {
    int          kind;
    logic [20:0] adr;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] out;
    logic [15:0] dat;
  } exp_t;

  exp_t sb[$];
  int   compared = 0, mismatched = 0;
  bit   err_seen = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_p);
      #1;
    end
  endtask

  always @(negedge clk_p) begin
    exp_t e;
    logic ev;
    int   kind;
    kind = m0_ack ? 0 : m1_ack ? 1 : m0_err ? 2 : 3;
    ev = !sdram_reset && (m0_ack || m1_ack || ((m0_err || m1_err) && !err_seen));
    err_seen = m0_err || m1_err;
    if (ev) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_unexpected: got event kind %0d, expected none", kind);
      end else begin
        e = sb.pop_front();
        check("sb_kind", kind, e.kind);
        if (kind < 2) begin
          check("sb_adr", sdram_adr, e.adr);
          check("sb_we", sdram_we, e.we);
          check("sb_sel", sdram_sel, e.sel);
          check("sb_out", sdram_out, e.out);
          check("sb_dat", m_dat_i, e.dat);
          check("sb_dual_ack", m0_ack && m1_ack, 0);
        end else begin
          check("sb_err_tmo_flag", tmo_flag, 1);
          check("sb_err_stb", sdram_stb, 0);
        end
      end
    end
  end

  initial begin
    int cnt;
    {m0_stb, m1_stb, m0_we, m1_we} = '0;
    m0_sel = 2'b11; m1_sel = 2'b11; m0_adr = '0; m1_adr = '0;
    m0_dat_o = '0; m1_dat_o = '0; sdram_dat = '0;
    sdram_ready = 1'b1; sdram_ack = 1'b1;
    tick(2); #2;
    check("rst_stb", sdram_stb, 0);
    check("rst_tmo", tmo_flag, 0);
    check("rst_adr", sdram_adr, 0);
    check("rst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    sdram_ack = 1'b0;
    tick(1);
    sdram_reset = 1'b0;

    // m0 read, slave acks in the 5th strobe cycle
    tick(1);
    m0_stb = 1'b1; m0_adr = 21'h000100; m0_dat_o = 16'hBEEF; sdram_dat = 16'h1234;
    sb.push_back(exp_t'{0, 21'h000100, 1'b0, 2'b11, 16'hBEEF, 16'h1234});
    #2 check("t1_stb_c0", sdram_stb, 0);
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      if (c == 5) sdram_ack = 1'b1;
      #2;
      check($sformatf("t1_stb_c%0d", c), sdram_stb, 1);
      check($sformatf("t1_m0ack_c%0d", c), m0_ack, c == 5);
      check($sformatf("t1_m1ack_c%0d", c), m1_ack, 0);
    end
    tick(1); sdram_ack = 1'b0; m0_stb = 1'b0;
    #2 check("t1_gnt_last", sdram_stb, 1);
    tick(1); #2 check("t1_rel_stb", sdram_stb, 0);
    tick(2);

    // simultaneous requests after reset: m0 first, then m1 after REL and IDLE
    sdram_reset = 1'b1; tick(1); sdram_reset = 1'b0; tick(1);
    m0_stb = 1'b1; m1_stb = 1'b1;
    m0_adr = 21'h0AAAA; m1_adr = 21'h15555;
    m0_dat_o = 16'h1111; m1_dat_o = 16'h2222; sdram_dat = 16'h5A5A;
    sb.push_back(exp_t'{0, 21'h0AAAA, 1'b0, 2'b11, 16'h1111, 16'h5A5A});
    sb.push_back(exp_t'{1, 21'h15555, 1'b0, 2'b11, 16'h2222, 16'hC3C3});
    tick(1); #2;
    check("t2_gnt0_stb", sdram_stb, 1);
    check("t2_gnt0_adr", sdram_adr, 21'h0AAAA);
    tick(1); sdram_ack = 1'b1;
    tick(1); sdram_ack = 1'b0; m0_stb = 1'b0;
    tick(1); #2;
    check("t2_rel_stb", sdram_stb, 0);
    check("t2_rel_adr", sdram_adr, 0);
    tick(1); #2 check("t2_idle_stb", sdram_stb, 0);
    tick(1); sdram_dat = 16'hC3C3;
    #2;
    check("t2_gnt1_stb", sdram_stb, 1);
    check("t2_gnt1_adr", sdram_adr, 21'h15555);
    tick(1); sdram_ack = 1'b1;
    tick(1); sdram_ack = 1'b0; m1_stb = 1'b0;
    tick(3);

    // m1 byte write
    m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 2'b10; m1_adr = 21'h1F0F0;
    m1_dat_o = 16'hA55A; sdram_dat = 16'h0000;
    sb.push_back(exp_t'{1, 21'h1F0F0, 1'b1, 2'b10, 16'hA55A, 16'h0000});
    tick(1); #2;
    check("t3_we", sdram_we, 1);
    check("t3_sel", sdram_sel, 2'b10);
    check("t3_out", sdram_out, 16'hA55A);
    tick(1); sdram_ack = 1'b1;
    tick(1); sdram_ack = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick(3);

    // sdram_ready gating; ready dropping mid-grant must not abort
    sdram_ready = 1'b0;
    m0_stb = 1'b1; m0_adr = 21'h00042; m0_dat_o = 16'h0000; sdram_dat = 16'h7777;
    sb.push_back(exp_t'{0, 21'h00042, 1'b0, 2'b11, 16'h0000, 16'h7777});
    for (int c = 0; c < 3; c++) begin
      tick(1); #2 check($sformatf("t4_blocked_c%0d", c), sdram_stb, 0);
    end
    tick(1); sdram_ready = 1'b1;
    #2 check("t4_ready_rise", sdram_stb, 0);
    tick(1); #2 check("t4_granted", sdram_stb, 1);
    tick(1); sdram_ready = 1'b0;
    #2 check("t4_ready_drop_hold", sdram_stb, 1);
    tick(1); sdram_ack = 1'b1; sdram_ready = 1'b1;
    tick(1); sdram_ack = 1'b0; m0_stb = 1'b0;
    tick(3);

    // timeout: slave never acks
    m0_stb = 1'b1; m0_adr = 21'h00077;
    sb.push_back(exp_t'{2, 21'h0, 1'b0, 2'b00, 16'h0, 16'h0});
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1); #2;
      if (sdram_stb) cnt++;
    end
    check("t5_stb_cycles", cnt, 8);
    check("t5_m0_err", m0_err, 1);
    check("t5_m1_err", m1_err, 0);
    check("t5_tmo_flag", tmo_flag, 1);
    check("t5_err_adr", sdram_adr, 0);
    tick(1); m0_stb = 1'b0;
    #2 check("t5_err_clear", m0_err, 0);
    tick(1); #2 check("t5_rel_stb", sdram_stb, 0);
    tick(2); #2 check("t5_tmo_sticky", tmo_flag, 1);

    // reset pulse during GNT1
    m1_stb = 1'b1; m1_adr = 21'h0BEEF;
    tick(1); #2;
    check("t6_gnt1_stb", sdram_stb, 1);
    check("t6_tmo_before_rst", tmo_flag, 1);
    #1 sdram_reset = 1'b1;
    #1;
    check("t6_rst_stb", sdram_stb, 0);
    check("t6_rst_adr", sdram_adr, 0);
    check("t6_rst_tmo", tmo_flag, 0);
    tick(1);
    sdram_reset = 1'b0;
    m0_stb = 1'b1; m0_adr = 21'h00321; m0_dat_o = 16'h0000; sdram_dat = 16'h0F0F;
    sb.push_back(exp_t'{0, 21'h00321, 1'b0, 2'b11, 16'h0000, 16'h0F0F});
    #2 check("t6_idle_stb", sdram_stb, 0);
    tick(1); #2;
    check("t6_tie_stb", sdram_stb, 1);
    check("t6_tie_adr", sdram_adr, 21'h00321);
    tick(1); sdram_ack = 1'b1;
    tick(1); sdram_ack = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
    tick(4);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
